// File: rtl/loopyV_data_types.sv
// loopyV_data_types: load/store FSM states, funct3 encodings and byte-enable helper.
package loopyV_data_types;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} lsu_state_t;
    localparam logic [2:0] FUNCT3_BYTE   = 3'b000;
    localparam logic [2:0] FUNCT3_HALF   = 3'b001;
    localparam logic [2:0] FUNCT3_WORD   = 3'b010;
    localparam logic [2:0] FUNCT3_BYTE_U = 3'b100;
    localparam logic [2:0] FUNCT3_HALF_U = 3'b101;
    function automatic logic is_byte(input logic [2:0] f3);
        return f3 == FUNCT3_BYTE || f3 == FUNCT3_BYTE_U;
    endfunction
    function automatic logic is_half(input logic [2:0] f3);
        return f3 == FUNCT3_HALF || f3 == FUNCT3_HALF_U;
    endfunction
    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] a);
        return is_byte(f3) ? 4'b0001 << a : is_half(f3) ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    endfunction
endpackage

// File: rtl/load_data_aligner.sv
// load_data_aligner: picks the addressed lane of a read word and sign/zero-extends it.
module load_data_aligner
    import loopyV_data_types::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        b = shifted[7:0];
        h = offset[1] ? rdata[31:16] : rdata[15:0];
        data = funct3 == FUNCT3_BYTE   ? {{24{b[7]}}, b} :
               funct3 == FUNCT3_BYTE_U ? {24'b0, b} :
               funct3 == FUNCT3_HALF   ? {{16{h[15]}}, h} :
               funct3 == FUNCT3_HALF_U ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage data bus master; issues one aligned access at a time and stalls the pipeline until it completes.
module load_store_unit
    import loopyV_data_types::*;
(
    input  logic        clk,
    input  logic        arstn,
    input  logic        loadSignalMEM,
    input  logic        storeSignalMEM,
    input  logic [2:0]  loadStoreByteSelectMEM,
    input  logic [31:0] storeDataMEM,
    input  logic [31:0] dmAddrMEM,
    output logic        stallMEM,
    output logic [31:0] loadDataMEM,
    output logic        misalignedMEM,
    output logic        accessFaultMEM,
    output logic        dmReq,
    output logic        dmWe,
    output logic [3:0]  dmBe,
    output logic [31:0] dmAddr,
    output logic [31:0] dmWdata,
    input  logic        dmGnt,
    input  logic        dmRvalid,
    input  logic [31:0] dmRdata,
    input  logic        dmErr
);
    lsu_state_t state, state_next;
    logic access, misaligned, aligned_access, resp;
    logic [31:0] aligned_rdata;

    assign access = loadSignalMEM | storeSignalMEM;
    assign misaligned = (is_half(loadStoreByteSelectMEM) & dmAddrMEM[0]) |
                        (loadStoreByteSelectMEM == FUNCT3_WORD & |dmAddrMEM[1:0]);
    assign aligned_access = access & ~misaligned;
    assign misalignedMEM = access & misaligned;
    // Gated by arstn so a reset mid-transaction drops the request and stall at once.
    assign dmReq = arstn & ((state == IDLE & aligned_access) | state == REQ);
    assign stallMEM = arstn & aligned_access & state != DONE;
    assign dmWe = storeSignalMEM;
    assign dmBe = byte_enables(loadStoreByteSelectMEM, dmAddrMEM[1:0]);
    assign dmAddr = {dmAddrMEM[31:2], 2'b00};
    assign dmWdata = is_byte(loadStoreByteSelectMEM) ? {4{storeDataMEM[7:0]}} :
                     is_half(loadStoreByteSelectMEM) ? {2{storeDataMEM[15:0]}} : storeDataMEM;
    assign resp = state == WAIT_RESP & dmRvalid;

    load_data_aligner u_aligner (
        .rdata  (dmRdata),
        .offset (dmAddrMEM[1:0]),
        .funct3 (loadStoreByteSelectMEM),
        .data   (aligned_rdata)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = aligned_access ? (dmGnt ? WAIT_RESP : REQ) : IDLE;
            REQ:       state_next = dmGnt ? WAIT_RESP : REQ;
            WAIT_RESP: state_next = dmRvalid ? DONE : WAIT_RESP;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
            loadDataMEM <= '0;
            accessFaultMEM <= 1'b0;
        end else begin
            state <= state_next;
            accessFaultMEM <= resp & dmErr;
            if (resp & (dmErr | loadSignalMEM))
                loadDataMEM <= dmErr ? '0 : aligned_rdata;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for load_store_unit against an arithmetic reference model.
module tb_load_store_unit;
    logic clk = 1'b0, arstn = 1'b0;
    logic loadSignalMEM = 0, storeSignalMEM = 0, dmGnt = 0, dmRvalid = 0, dmErr = 0;
    logic [2:0] loadStoreByteSelectMEM = 0;
    logic [31:0] storeDataMEM = 0, dmAddrMEM = 0, dmRdata = 0;
    logic stallMEM, misalignedMEM, accessFaultMEM, dmReq, dmWe;
    logic [31:0] loadDataMEM, dmAddr, dmWdata;
    logic [3:0] dmBe;

    typedef struct { bit mis; logic [31:0] data; bit fault; int stall; } resp_t;
    typedef struct { logic [31:0] addr; logic [3:0] be; bit we; logic [31:0] wdata; } bus_t;
    resp_t rq[$];
    bus_t bq[$];
    int compared = 0, mismatched = 0;
    logic [31:0] last_load = 0;

    load_store_unit dut (
        .clk(clk), .arstn(arstn), .loadSignalMEM(loadSignalMEM), .storeSignalMEM(storeSignalMEM),
        .loadStoreByteSelectMEM(loadStoreByteSelectMEM), .storeDataMEM(storeDataMEM), .dmAddrMEM(dmAddrMEM),
        .stallMEM(stallMEM), .loadDataMEM(loadDataMEM), .misalignedMEM(misalignedMEM),
        .accessFaultMEM(accessFaultMEM), .dmReq(dmReq), .dmWe(dmWe), .dmBe(dmBe), .dmAddr(dmAddr),
        .dmWdata(dmWdata), .dmGnt(dmGnt), .dmRvalid(dmRvalid), .dmRdata(dmRdata), .dmErr(dmErr)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] rd);
        int unsigned b = (rd >> (8 * (addr % 4))) & 32'hFF;
        int unsigned h = (rd >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0: return b >= 128 ? b - 256 : b;
            3'd1: return h >= 32768 ? h - 65536 : h;
            3'd4: return b;
            3'd5: return h;
            default: return rd;
        endcase
    endfunction

    task automatic clear_inputs();
        loadSignalMEM = 0;
        storeSignalMEM = 0;
        dmGnt = 0;
        dmRvalid = 0;
        dmErr = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(bit ld, logic [2:0] f3, logic [31:0] addr, logic [31:0] data,
                         int gd, int rd, logic [31:0] rdata, bit err);
        bit is_b = f3 == 0 || f3 == 4;
        bit is_h = f3 == 1 || f3 == 5;
        bit mis = is_h ? addr % 2 != 0 : f3 == 2 ? addr % 4 != 0 : 0;
        resp_t r;
        bus_t b;
        loadSignalMEM = ld;
        storeSignalMEM = !ld;
        loadStoreByteSelectMEM = f3;
        dmAddrMEM = addr;
        storeDataMEM = data;
        if (mis) begin
            r = '{1, 0, 0, 0};
            rq.push_back(r);
            cyc();
            clear_inputs();
            return;
        end
        b.addr = addr - addr % 4;
        b.be = is_b ? 4'(1 << (addr % 4)) : is_h ? 4'(3 << (addr % 4 / 2 * 2)) : 4'hF;
        b.we = !ld;
        b.wdata = is_b ? (data & 32'hFF) * 32'h01010101 : is_h ? (data & 32'hFFFF) * 32'h00010001 : data;
        bq.push_back(b);
        if (err) last_load = 0;
        else if (ld) last_load = model_load(f3, addr, rdata);
        r = '{0, last_load, err, gd + rd + 2};
        rq.push_back(r);
        for (int i = 0; i < gd; i++) begin
            dmRvalid = $urandom % 3 == 0;
            dmErr = 1'($urandom);
            dmRdata = $urandom;
            cyc();
        end
        dmRvalid = 0;
        dmErr = 0;
        dmGnt = 1;
        cyc();
        dmGnt = 0;
        repeat (rd) cyc();
        dmRvalid = 1;
        dmRdata = rdata;
        dmErr = err;
        cyc();
        dmRvalid = 0;
        dmErr = 0;
        dmRdata = $urandom;
        cyc();
        clear_inputs();
    endtask

    task automatic idle_gap(int n);
        repeat (n) begin
            dmRvalid = $urandom % 2 == 0;
            dmErr = 1'($urandom);
            dmRdata = $urandom;
            cyc();
        end
        dmRvalid = 0;
        dmErr = 0;
    endtask

    initial begin : monitor
        int stall_cnt = 0;
        resp_t r;
        forever begin
            @(negedge clk);
            if (!arstn) begin
                stall_cnt = 0;
                continue;
            end
            if (dmReq) begin
                if (bq.size() == 0) check("bus_unexpected_req", dmReq, 0);
                else begin
                    check("dmAddr", dmAddr, bq[0].addr);
                    check("dmBe", dmBe, bq[0].be);
                    check("dmWe", dmWe, bq[0].we);
                    check("dmWdata", dmWdata, bq[0].wdata);
                    if (dmGnt) void'(bq.pop_front());
                end
            end
            if (stallMEM) stall_cnt++;
            if ((loadSignalMEM | storeSignalMEM) && (misalignedMEM || !stallMEM)) begin
                if (rq.size() == 0) check("resp_unexpected", rq.size(), 1);
                else begin
                    r = rq.pop_front();
                    check("misalignedMEM", misalignedMEM, r.mis);
                    if (r.mis) begin
                        check("mis_dmReq", dmReq, 0);
                        check("mis_stallMEM", stallMEM, 0);
                    end else begin
                        check("loadDataMEM", loadDataMEM, r.data);
                        check("accessFaultMEM", accessFaultMEM, r.fault);
                        check("stall_cycles", stall_cnt, r.stall);
                    end
                end
                stall_cnt = 0;
            end else check("fault_outside_done", accessFaultMEM, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_t b;
        logic [2:0] lf3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        #12;
        check("rst_dmReq", dmReq, 0);
        check("rst_stallMEM", stallMEM, 0);
        check("rst_loadDataMEM", loadDataMEM, 0);
        check("rst_accessFaultMEM", accessFaultMEM, 0);
        cyc();
        arstn = 1;
        idle_gap(2);
        issue(1, 3'd2, 32'h100, $urandom, 0, 0, 32'hDEADBEEF, 0);
        issue(1, 3'd0, 32'h103, $urandom, 0, 1, 32'h80FFFFFF, 0);
        issue(1, 3'd4, 32'h103, $urandom, 1, 0, 32'h80FFFFFF, 0);
        issue(0, 3'd1, 32'h202, 32'h1234ABCD, 3, 0, $urandom, 0);
        issue(1, 3'd2, 32'h101, $urandom, 0, 0, $urandom, 0);
        issue(1, 3'd1, 32'h40, $urandom, 0, 0, 32'h12345678, 1);
        idle_gap(1);
        for (int i = 0; i < 250; i++) begin
            bit ld = 1'($urandom);
            issue(ld, ld ? lf3[$urandom % 5] : 3'($urandom % 3), $urandom, $urandom,
                  $urandom % 4, $urandom % 4, $urandom, $urandom % 6 == 0);
            if ($urandom % 3 == 0) idle_gap(1 + $urandom % 2);
        end
        loadSignalMEM = 1;
        loadStoreByteSelectMEM = 3'd2;
        dmAddrMEM = 32'h300;
        b = '{32'h300, 4'hF, 0, storeDataMEM};
        bq.push_back(b);
        dmGnt = 1;
        cyc();
        dmGnt = 0;
        #2;
        arstn = 0;
        #1;
        check("midrst_dmReq", dmReq, 0);
        check("midrst_stallMEM", stallMEM, 0);
        check("midrst_loadDataMEM", loadDataMEM, 0);
        cyc();
        clear_inputs();
        arstn = 1;
        last_load = 0;
        dmRvalid = 1;
        dmErr = 1;
        dmRdata = 32'hCAFEF00D;
        cyc();
        dmRvalid = 0;
        dmErr = 0;
        issue(0, 3'd2, 32'h400, 32'h55AA55AA, 0, 0, $urandom, 0);
        idle_gap(3);
        check("resp_queue_drained", rq.size(), 0);
        check("bus_queue_drained", bq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
